// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry and shared typedefs for the integer register file
package reg_file_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);
    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read/write/alloc port bundle between issue/writeback logic and the register file
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     alloc_en;
    logic [AW-1:0]            alloc_addr;
    logic                     flush;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits; flush beats alloc, alloc beats writeback clear
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR-1:0][AW-1:0] wr_addr,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy
);
    logic [NREGS-1:0] busy_nxt;
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j]) busy_nxt[wr_addr[j]] = 1'b0;
        if (alloc_en && !flush) busy_nxt[alloc_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with busy-bit scoreboard, x0 hardwired to zero
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NRD-1:0][XLEN-1:0]   rd_data;
    logic [NRD-1:0]             rd_busy;
    reg_file_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .busy       (busy)
    );
    // Later ports are visited last, so the highest-index writer to an address wins.
    always_ff @(posedge clk or posedge rst)
        if (rst) regs <= '0;
        else
            for (int j = 0; j < NWR; j++)
                if (bus.wr_en[j] && bus.wr_addr[j] != '0) regs[bus.wr_addr[j]] <= bus.wr_data[j];
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data[i] = regs[bus.rd_addr[i]];
            rd_busy[i] = busy[bus.rd_addr[i]];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NWR; j++)
                if (!rst && bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i] && bus.rd_addr[i] != '0) begin
                    rd_data[i] = bus.wr_data[j];
                    rd_busy[i] = 1'b0;
                end
`else
`endif
        end
    end
    assign bus.rd_data = rd_data;
    assign bus.rd_busy = rd_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors for reg_file_sb with two write ports; honours REG_FILE_BYPASS_EN
module tb_reg_file_sb;
    import reg_file_pkg::*;
    localparam int NRD = 2;
    localparam int NWR = 2;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    always #5 clk = ~clk;
    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(NRD), .NWR(NWR)) bus ();
    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle;
        bus.wr_en    = '0;
        bus.alloc_en = 1'b0;
        bus.flush    = 1'b0;
    endtask
    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr[0] = a0;
        bus.rd_addr[1] = a1;
        #1;
    endtask
    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        bus.wr_en[p]   = 1'b1;
        bus.wr_addr[p] = a;
        bus.wr_data[p] = d;
    endtask
    task automatic alloc(input logic [4:0] a);
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = a;
    endtask
    initial begin
        idle();
        bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.alloc_addr = '0;
        #1;
        check("rst_data", bus.rd_data[0], 32'h0);
        check("rst_busy", 32'(bus.rd_busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            check("init_d0", bus.rd_data[0], 32'h0);
            check("init_d1", bus.rd_data[1], 32'h0);
            check("init_busy", 32'(bus.rd_busy), 32'h0);
        end
        // basic write x5
        tick();
        wr(0, 5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd0);
        check("x5_same", bus.rd_data[0], BYP ? 32'hDEADBEEF : 32'h0);
        tick(); idle(); #1;
        check("x5_next", bus.rd_data[0], 32'hDEADBEEF);
        // x0 write ignored
        wr(0, 5'd0, 32'h12345678);
        rd(5'd0, 5'd5);
        check("x0_same", bus.rd_data[0], 32'h0);
        tick(); idle(); #1;
        check("x0_next", bus.rd_data[0], 32'h0);
        check("x5_keep", bus.rd_data[1], 32'hDEADBEEF);
        // same-cycle read of x7 with non-zero old value
        wr(1, 5'd7, 32'h11111111);
        tick(); idle();
        wr(0, 5'd7, 32'hA5A5A5A5);
        rd(5'd7, 5'd7);
        check("x7_same", bus.rd_data[0], BYP ? 32'hA5A5A5A5 : 32'h11111111);
        tick(); idle(); #1;
        check("x7_next", bus.rd_data[1], 32'hA5A5A5A5);
        // two ports to x3: port 1 wins
        wr(0, 5'd3, 32'h1);
        wr(1, 5'd3, 32'h2);
        rd(5'd3, 5'd7);
        check("x3_same", bus.rd_data[0], BYP ? 32'h2 : 32'h0);
        tick(); idle(); #1;
        check("x3_next", bus.rd_data[0], 32'h2);
        // scoreboard: alloc, write clears
        alloc(5'd9);
        rd(5'd8, 5'd9);
        check("b9_same", 32'(bus.rd_busy[1]), 32'h0);
        tick(); idle(); #1;
        check("b9_set", 32'(bus.rd_busy[1]), 32'h1);
        check("b8_clr", 32'(bus.rd_busy[0]), 32'h0);
        wr(0, 5'd9, 32'h99);
        #1;
        check("b9_wr_same", 32'(bus.rd_busy[1]), BYP ? 32'h0 : 32'h1);
        tick(); idle(); #1;
        check("b9_wr_clr", 32'(bus.rd_busy[1]), 32'h0);
        check("x9_data", bus.rd_data[1], 32'h99);
        // alloc + write same edge: new producer wins
        alloc(5'd9);
        wr(1, 5'd9, 32'hABCD);
        tick(); idle(); #1;
        check("x9_aw_data", bus.rd_data[1], 32'hABCD);
        check("b9_aw_busy", 32'(bus.rd_busy[1]), 32'h1);
        // flush drops same-cycle alloc, still commits write
        bus.flush = 1'b1;
        alloc(5'd10);
        wr(0, 5'd11, 32'h55);
        tick(); idle();
        rd(5'd10, 5'd9);
        check("b9_flush", 32'(bus.rd_busy[1]), 32'h0);
        check("b10_flush", 32'(bus.rd_busy[0]), 32'h0);
        rd(5'd11, 5'd9);
        check("x11_flush", bus.rd_data[0], 32'h55);
        // port 1 write clears busy; alloc to x0 ignored
        alloc(5'd13);
        tick(); idle();
        rd(5'd13, 5'd0);
        check("b13_set", 32'(bus.rd_busy[0]), 32'h1);
        wr(1, 5'd13, 32'h13);
        alloc(5'd0);
        tick(); idle(); #1;
        check("b13_p1_clr", 32'(bus.rd_busy[0]), 32'h0);
        check("b0_alloc", 32'(bus.rd_busy[1]), 32'h0);
        // asynchronous reset between edges, discarding an in-flight write
        alloc(5'd20);
        tick(); idle();
        rd(5'd5, 5'd20);
        check("b20_pre", 32'(bus.rd_busy[1]), 32'h1);
        wr(0, 5'd6, 32'h66);
        #1 rst = 1'b1;
        #1;
        check("arst_x5", bus.rd_data[0], 32'h0);
        check("arst_b20", 32'(bus.rd_busy[1]), 32'h0);
        tick(); idle();
        rst = 1'b0;
        rd(5'd6, 5'd7);
        check("arst_x6", bus.rd_data[0], 32'h0);
        check("arst_x7", bus.rd_data[1], 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
